board_scanner: RTL and testbench

- Read-side counterpart to the board state registers (dff-based, write-enabled).
- On `start`, takes a snapshot of the flattened Conway board and streams it out one cell per transfer over a valid/ready handshake.
- Each transfer carries the cell's row/column coordinates and a last flag.
- Feeds display, serial-dump and debug consumers that need the board in raster order.

---
 rtl/board_scanner.sv | 133 +++++++++++++
 tb/tb_board_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_scanner.sv
// board_scanner: snapshots a flattened Conway board on start and streams it out one cell per
// valid/ready transfer in raster order, tagging each cell with row, column and a last flag.
// Optional feature macro: BOARD_SCANNER_SKIP_DEAD_EN (present only live cells, skip dead ones).
module board_scanner #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*HEIGHT-1:0]   board,
  input  logic                      start,
  output logic                      busy,
  output logic                      cell_valid,
  input  logic                      cell_ready,
  output logic                      cell_alive,
  output logic [RW-1:0]             cell_row,
  output logic [CW-1:0]             cell_col,
  output logic                      cell_last,
  output logic                      done
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] ColMax = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowMax = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StFin} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    snap_q, snap_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic            cur_bit;
  logic            at_last;
  logic            xfer;
  logic            advance;

  // Outputs are pure decodes of registered state; nothing here looks at board or cell_ready.
  always_comb begin
    cur_bit = snap_q[idx_q];
    busy    = (state_q == StScan);
    done    = (state_q == StFin);
`ifdef BOARD_SCANNER_SKIP_DEAD_EN
    // Visited bits are cleared, so "last" means nothing else is left set in the snapshot.
    at_last    = ((snap_q & ~({{(N-1){1'b0}}, 1'b1} << idx_q)) == '0);
    cell_valid = busy & cur_bit;
`else
    at_last    = (row_q == RowMax) && (col_q == ColMax);
    cell_valid = busy;
`endif
    cell_alive = busy & cur_bit;
    cell_last  = busy & at_last;
    cell_row   = row_q;
    cell_col   = col_q;
  end

  // Next-state: capture on start, step the raster position on each transfer (or skip).
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    xfer    = cell_valid & cell_ready;
`ifdef BOARD_SCANNER_SKIP_DEAD_EN
    advance = xfer | (busy & ~cur_bit);
`else
    advance = xfer;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = board;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (advance) begin
`ifdef BOARD_SCANNER_SKIP_DEAD_EN
          snap_d[idx_q] = 1'b0;
`endif
          if (at_last) begin
            // Park counters at the origin so idle outputs read as zero.
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
            state_d = StFin;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == ColMax) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner: a 4x4 and a 1x3 instance run against a raster-order
// reference model; literal expectations pin the model on the directed scenarios.
module tb_board_scanner;

`ifdef BOARD_SCANNER_SKIP_DEAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] board0 = '0;
  logic        start0 = 1'b0, ready0 = 1'b0;
  logic        busy0, valid0, alive0, last0, done0;
  logic [1:0]  row0, col0;

  logic [2:0]  board1 = '0;
  logic        start1 = 1'b0, ready1 = 1'b0;
  logic        busy1, valid1, alive1, last1, done1;
  logic [1:0]  row1;
  logic [0:0]  col1;

  board_scanner #(.WIDTH(4), .HEIGHT(4)) u_dut0 (
    .clk(clk), .reset(reset), .board(board0), .start(start0), .busy(busy0),
    .cell_valid(valid0), .cell_ready(ready0), .cell_alive(alive0), .cell_row(row0),
    .cell_col(col0), .cell_last(last0), .done(done0)
  );

  board_scanner #(.WIDTH(1), .HEIGHT(3)) u_dut1 (
    .clk(clk), .reset(reset), .board(board1), .start(start1), .busy(busy1),
    .cell_valid(valid1), .cell_ready(ready1), .cell_alive(alive1), .cell_row(row1),
    .cell_col(col1), .cell_last(last1), .done(done1)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 scanning at linear index m_i, 2 done cycle.
  int          ww[2] = '{4, 1};
  int          nn[2] = '{16, 3};
  int          m_phase[2] = '{0, 0};
  int          m_i[2] = '{0, 0};
  logic [15:0] m_snap[2] = '{16'h0, 16'h0};

  function automatic bit exp_valid(input int k);
    return (m_phase[k] == 1) && (SKIP ? m_snap[k][m_i[k]] : 1'b1);
  endfunction

  function automatic bit exp_last(input int k);
    if (SKIP) return (m_snap[k] >> (m_i[k] + 1)) == 16'h0;
    return m_i[k] == nn[k] - 1;
  endfunction

  task automatic mstep(input int k, input bit rst, input bit st, input logic [15:0] brd,
                       input bit rdy);
    bit v;
    if (rst) begin
      m_phase[k] = 0; m_i[k] = 0; m_snap[k] = '0;
    end else if (m_phase[k] == 0) begin
      if (st) begin m_snap[k] = brd; m_i[k] = 0; m_phase[k] = 1; end
    end else if (m_phase[k] == 1) begin
      v = exp_valid(k);
      if ((v && rdy) || (SKIP && !v)) begin
        if (exp_last(k)) begin
          m_phase[k] = 2; m_i[k] = 0;
        end else begin
          if (SKIP) m_snap[k][m_i[k]] = 1'b0;
          m_i[k]++;
        end
        if (SKIP && m_phase[k] == 2) m_snap[k] = '0;
      end
    end else begin
      m_phase[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    mstep(0, reset, start0, board0, ready0);
    mstep(1, reset, start1, {13'h0, board1}, ready1);
  end

  task automatic cmp(input int k, input logic b, input logic v, input logic a, input int r,
                     input int c, input logic l, input logic d);
    bit scan;
    scan = (m_phase[k] == 1);
    chk($sformatf("busy%0d", k), b, scan);
    chk($sformatf("valid%0d", k), v, exp_valid(k));
    chk($sformatf("alive%0d", k), a, scan && m_snap[k][m_i[k]]);
    chk($sformatf("row%0d", k), r, scan ? m_i[k] / ww[k] : 0);
    chk($sformatf("col%0d", k), c, scan ? m_i[k] % ww[k] : 0);
    if (exp_valid(k) || !scan) chk($sformatf("last%0d", k), l, scan && exp_last(k));
    chk($sformatf("done%0d", k), d, m_phase[k] == 2);
  endtask

  // Transfers seen, encoded alive*1000 + row*100 + col*10 + last.
  int xq0[$];
  int xq1[$];
  int xref[$];

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, busy0, valid0, alive0, int'(row0), int'(col0), last0, done0);
      cmp(1, busy1, valid1, alive1, int'(row1), int'(col1), last1, done1);
      if (valid0 && ready0) xq0.push_back(alive0 * 1000 + row0 * 100 + col0 * 10 + last0);
      if (valid1 && ready1) xq1.push_back(alive1 * 1000 + row1 * 100 + col1 * 10 + last1);
    end
  end

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready high plus mid-scan board/start poke.
  task automatic run_scan0(input logic [15:0] brd, input int mode, output int cyc);
    bit seen;
    bit poked;
    xq0.delete();
    board0 = brd; start0 = 1'b1; ready0 = 1'b1;
    cyc = 1; seen = 1'b0; poked = 1'b0;
    @(posedge clk); #1;
    cyc++;
    start0 = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (mode == 1) ready0 = (c % 4 == 0) || (c % 4 == 3);
      start0 = 1'b0;
      if (mode == 2 && !poked && xq0.size() == (SKIP ? 1 : 5)) begin
        board0 = 16'hFFFF; start0 = 1'b1; poked = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (done0) seen = 1'b1;
    end
    start0 = 1'b0;
    chk("scan0_done_timeout", seen, 1'b1);
  endtask

  task automatic cmp_ref(input string name);
    chk({name, "_count"}, xq0.size(), xref.size());
    for (int i = 0; i < xref.size() && i < xq0.size(); i++)
      chk($sformatf("%s_xfer%0d", name, i), xq0[i], xref[i]);
  endtask

  initial begin
    int cyc;
    int alive_cnt;
    int dcount;
    bit hit;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_rowcol", {row0, col0}, 4'h0);
    chk("rst_done", done0, 1'b0);

    // Sparse board, ready held high.
    run_scan0(16'h8001, 0, cyc);
    chk("t1_count", xq0.size(), SKIP ? 2 : 16);
    if (xq0.size() > 0) begin
      chk("t1_first", xq0[0], 1000);
      chk("t1_final", xq0[xq0.size() - 1], 1331);
    end
    alive_cnt = 0;
    foreach (xq0[i]) if (xq0[i] >= 1000) alive_cnt++;
    chk("t1_alive_cnt", alive_cnt, 2);
    if (!SKIP && xq0.size() == 16) chk("t1_xfer5", xq0[5], 110);
    chk("t1_cycles", cyc, 18);
    xref = xq0;

    // Same board with stalls.
    @(posedge clk); #1;
    run_scan0(16'h8001, 1, cyc);
    cmp_ref("t2");

    // Mid-scan board change and extra start must not disturb the snapshot.
    @(posedge clk); #1;
    run_scan0(16'h8001, 2, cyc);
    cmp_ref("t3");

    // Reset while presenting (2,1).
    @(posedge clk); #1;
    board0 = 16'hFFFF; start0 = 1'b1; ready0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (valid0 && row0 == 2'd2 && col0 == 2'd1) hit = 1'b1;
    end
    chk("t4_reach_2_1", hit, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy0, 1'b0);
    chk("t4_valid", valid0, 1'b0);
    chk("t4_alive", alive0, 1'b0);
    chk("t4_rowcol", {row0, col0}, 4'h0);
    chk("t4_last", last0, 1'b0);
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (done0) dcount++;
      @(negedge clk);
    end
    chk("t4_no_done", dcount, 0);
    @(posedge clk); #1;
    run_scan0(16'hFFFF, 0, cyc);
    if (xq0.size() > 0) chk("t4_restart_first", xq0[0], 1000);
    chk("t4_restart_count", xq0.size(), 16);

`ifdef BOARD_SCANNER_SKIP_DEAD_EN
    @(posedge clk); #1;
    run_scan0(16'h0240, 0, cyc);
    chk("skip_count", xq0.size(), 2);
    if (xq0.size() == 2) begin
      chk("skip_x0", xq0[0], 1120);
      chk("skip_x1", xq0[1], 1211);
    end
    @(posedge clk); #1;
    run_scan0(16'h0000, 0, cyc);
    chk("skip_empty_count", xq0.size(), 0);
`endif

    // Single-column board.
    xq1.delete();
    board1 = 3'b101; start1 = 1'b1; ready1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk); #1;
      if (done1) hit = 1'b1;
    end
    chk("w1_done_timeout", hit, 1'b1);
    chk("w1_count", xq1.size(), SKIP ? 2 : 3);
    if (!SKIP && xq1.size() == 3) begin
      chk("w1_x0", xq1[0], 1000);
      chk("w1_x1", xq1[1], 100);
      chk("w1_x2", xq1[2], 1201);
    end
    if (SKIP && xq1.size() == 2) begin
      chk("w1_x0", xq1[0], 1000);
      chk("w1_x1", xq1[1], 1201);
    end

    // Randomised scans, including back-to-back starts and random stalls.
    for (int s = 0; s < 25; s++) begin
      board0 = 16'($urandom);
      start0 = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
        @(posedge clk); #1;
        if (done0) hit = 1'b1;
        if (c >= 1) start0 = ($urandom_range(0, 7) == 0);
        ready0 = ($urandom_range(0, 2) != 0);
        board0 = 16'($urandom);
        board1 = 3'($urandom);
        start1 = ($urandom_range(0, 3) == 0);
        ready1 = ($urandom_range(0, 1) == 1);
      end
      start0 = 1'b0;
      chk($sformatf("rand%0d_done_timeout", s), hit, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
